// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit ALU: registers {op,a,b}, waits SETTLE cycles, queues {op,result} in a FIFO.
// Optional issued-command counter enabled by defining ALU_CMD_SEQUENCER_STATS_EN.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [2:0]       alu_s,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [7:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [2:0]       res_op
`ifdef ALU_CMD_SEQUENCER_STATS_EN
  ,
  output logic [CNT_W-1:0] issued_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PW:0]   DEPTH_C  = (PW+1)'(DEPTH);
  localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE - 1);

  typedef enum logic {S_IDLE = 1'b0, S_DRIVE = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_settle;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [7:0]    r_mem_data [DEPTH];
  logic [2:0]    r_mem_op   [DEPTH];
  logic          w_cmd_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_accept ? S_DRIVE : S_IDLE;
      S_DRIVE: w_state_nxt = (r_settle == '0) ? S_IDLE : S_DRIVE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // cmd_ready depends only on registered state, so a pop frees a slot one cycle later
  always_comb begin
    w_cmd_ready = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:  w_cmd_ready = (r_count < DEPTH_C);
      S_DRIVE: w_push      = (r_settle == '0);
      default: begin
        w_cmd_ready = 1'b0;
        w_push      = 1'b0;
      end
    endcase
  end

  assign w_accept  = cmd_valid && w_cmd_ready;
  assign cmd_ready = w_cmd_ready;
  assign res_valid = (r_count != '0);
  assign w_pop     = res_valid && res_ready;
  assign res_data  = res_valid ? r_mem_data[r_rd_ptr] : 8'd0;
  assign res_op    = res_valid ? r_mem_op[r_rd_ptr]   : 3'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_s    <= 3'd0;
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      r_settle <= '0;
    end else if (w_accept) begin
      alu_s    <= cmd_op;
      alu_a    <= cmd_a;
      alu_b    <= cmd_b;
      r_settle <= SETTLE_C;
    end else if ((r_state == S_DRIVE) && (r_settle != '0)) begin
      r_settle <= r_settle - SW'(1);
    end
  end

  // Storage carries no reset: entries are only visible through the pointers/count
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem_data[r_wr_ptr] <= alu_out;
      r_mem_op[r_wr_ptr]   <= alu_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ALU_CMD_SEQUENCER_STATS_EN
  logic [CNT_W-1:0] r_issued;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issued <= '0;
    end else if (w_accept) begin
      r_issued <= r_issued + CNT_W'(1);
    end
  end

  assign issued_cnt = r_issued;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: two instances (SETTLE=1 and SETTLE=3) each driving a model ALU.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid1, cmd_ready1, res_valid1, res_ready1;
  logic [2:0] cmd_op1, alu_s1, res_op1;
  logic [3:0] cmd_a1, cmd_b1, alu_a1, alu_b1;
  logic [7:0] alu_out1, res_data1;
  logic       cmd_valid3, cmd_ready3, res_valid3, res_ready3;
  logic [2:0] cmd_op3, alu_s3, res_op3;
  logic [3:0] cmd_a3, cmd_b3, alu_a3, alu_b3;
  logic [7:0] alu_out3, res_data3;
`ifdef ALU_CMD_SEQUENCER_STATS_EN
  logic [3:0] issued_cnt1, issued_cnt3;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference 4-bit ALU: 0 add, 1 sub, 2 and, 3 or, 4 mul, 5 xor, 6 concat, 7 not-a
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] wa, wb;
    wa = {4'd0, a};
    wb = {4'd0, b};
    case (op)
      3'd0:    return wa + wb;
      3'd1:    return wa - wb;
      3'd2:    return wa & wb;
      3'd3:    return wa | wb;
      3'd4:    return wa * wb;
      3'd5:    return wa ^ wb;
      3'd6:    return {a, b};
      default: return {4'd0, ~a};
    endcase
  endfunction

  assign alu_out1 = alu_f(alu_s1, alu_a1, alu_b1);
  assign alu_out3 = alu_f(alu_s3, alu_a3, alu_b3);

  alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op1), .cmd_a(cmd_a1), .cmd_b(cmd_b1),
    .alu_s(alu_s1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_out(alu_out1),
    .res_valid(res_valid1), .res_ready(res_ready1),
    .res_data(res_data1), .res_op(res_op1)
`ifdef ALU_CMD_SEQUENCER_STATS_EN
    , .issued_cnt(issued_cnt1)
`endif
  );

  alu_cmd_sequencer #(.DEPTH(DEPTH), .SETTLE(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .alu_s(alu_s3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_out(alu_out3),
    .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .res_op(res_op3)
`ifdef ALU_CMD_SEQUENCER_STATS_EN
    , .issued_cnt(issued_cnt3)
`endif
  );

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, output bit ok);
    ok = 1'b0;
    cmd_valid1 = 1'b1; cmd_op1 = op; cmd_a1 = a; cmd_b1 = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = cmd_ready1;
      @(posedge clk); @(negedge clk);
    end
    cmd_valid1 = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (cmd_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready1); end
    n_cmp++; if (res_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid1); end
    n_cmp++; if ({res_op1, res_data1} !== 11'd0) begin n_fail++; $display("FAIL reset_res: got %h want 0", {res_op1, res_data1}); end
    n_cmp++; if ({alu_s1, alu_a1, alu_b1} !== 11'd0) begin n_fail++; $display("FAIL reset_alu: got %h want 0", {alu_s1, alu_a1, alu_b1}); end
    n_cmp++; if (res_valid3 !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid3: got %b want 0", res_valid3); end
  endtask

  task automatic test_basic();
    res_ready1 = 1'b1;
    cmd_valid1 = 1'b1; cmd_op1 = 3'd0; cmd_a1 = 4'd5; cmd_b1 = 4'd3;
    @(posedge clk); @(negedge clk);
    cmd_valid1 = 1'b0;
    n_cmp++; if ({alu_s1, alu_a1, alu_b1} !== {3'd0, 4'd5, 4'd3}) begin n_fail++; $display("FAIL basic_alu: got %h want %h", {alu_s1, alu_a1, alu_b1}, {3'd0, 4'd5, 4'd3}); end
    n_cmp++; if (cmd_ready1 !== 1'b0) begin n_fail++; $display("FAIL basic_drive_ready: got %b want 0", cmd_ready1); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (res_valid1 !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", res_valid1); end
    n_cmp++; if ({res_op1, res_data1} !== {3'd0, 8'h08}) begin n_fail++; $display("FAIL basic_data: got %h want %h", {res_op1, res_data1}, {3'd0, 8'h08}); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (res_valid1 !== 1'b0) begin n_fail++; $display("FAIL basic_after_pop: got %b want 0", res_valid1); end
    res_ready1 = 1'b0;
  endtask

  task automatic test_settle();
    bit bad = 1'b0;
    res_ready3 = 1'b1;
    cmd_valid3 = 1'b1; cmd_op3 = 3'd4; cmd_a3 = 4'd15; cmd_b3 = 4'd15;
    @(posedge clk); @(negedge clk);
    cmd_valid3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); @(negedge clk); end
      if (cmd_ready3 !== 1'b0 || res_valid3 !== 1'b0) bad = 1'b1;
    end
    n_cmp++; if (bad) begin n_fail++; $display("FAIL settle_hold: ready/valid seen high during DRIVE, want both 0"); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (res_valid3 !== 1'b1) begin n_fail++; $display("FAIL settle_valid: got %b want 1", res_valid3); end
    n_cmp++; if ({res_op3, res_data3} !== {3'd4, 8'hE1}) begin n_fail++; $display("FAIL settle_data: got %h want %h", {res_op3, res_data3}, {3'd4, 8'hE1}); end
    @(posedge clk); @(negedge clk);
    res_ready3 = 1'b0;
    n_cmp++; if (res_valid3 !== 1'b0) begin n_fail++; $display("FAIL settle_pop: got %b want 0", res_valid3); end
  endtask

  task automatic test_full();
    bit ok;
    bit stuck = 1'b1;
    int got = 0;
    res_ready1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send1(3'd0, 4'(k), 4'd1, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_accept%0d: got 0 want 1", k); end
    end
    cmd_valid1 = 1'b1; cmd_op1 = 3'd0; cmd_a1 = 4'd5; cmd_b1 = 4'd1;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready1 !== 1'b0) stuck = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    n_cmp++; if (!stuck) begin n_fail++; $display("FAIL full_blocked: cmd_ready rose with FIFO full, want 0"); end
    n_cmp++; if ({res_valid1, res_data1} !== {1'b1, 8'd2}) begin n_fail++; $display("FAIL full_head: got %h want %h", {res_valid1, res_data1}, {1'b1, 8'd2}); end
    res_ready1 = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready1 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      ok = cmd_ready1;
      @(posedge clk); @(negedge clk);
    end
    cmd_valid1 = 1'b0;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL full_accept5: got 0 want 1"); end
    res_ready1 = 1'b1;
    for (int i = 0; i < 40 && got < 4; i++) begin
      if (res_valid1 === 1'b1) begin
        n_cmp++; if (res_data1 !== 8'(got + 3)) begin n_fail++; $display("FAIL full_order%0d: got %0d want %0d", got, res_data1, got + 3); end
        got++;
      end
      @(posedge clk); @(negedge clk);
    end
    n_cmp++; if (got !== 4) begin n_fail++; $display("FAIL full_drain_count: got %0d want 4", got); end
    n_cmp++; if (res_valid1 !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b want 0", res_valid1); end
    res_ready1 = 1'b0;
  endtask

  task automatic test_random();
    logic [10:0] q[$];
    logic [10:0] e;
    int sent = 0;
    bit pend = 1'b0, acc, pop;
    logic [2:0] op = 3'd0;
    logic [3:0] a = 4'd0, b = 4'd0;
    for (int cyc = 0; cyc < 6000 && (sent < 200 || q.size() != 0); cyc++) begin
      if (!pend && sent < 200 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        op = 3'($urandom_range(0, 7));
        a  = 4'($urandom_range(0, 15));
        b  = 4'($urandom_range(0, 15));
      end
      cmd_valid1 = pend; cmd_op1 = op; cmd_a1 = a; cmd_b1 = b;
      res_ready1 = 1'($urandom_range(0, 1));
      acc = pend && (cmd_ready1 === 1'b1);
      pop = (res_valid1 === 1'b1) && res_ready1;
      n_cmp++; if (q.size() > DEPTH + 1) begin n_fail++; $display("FAIL rand_occupancy: got %0d want <= %0d", q.size(), DEPTH + 1); end
      if (q.size() >= 2) begin
        n_cmp++; if (res_valid1 !== 1'b1) begin n_fail++; $display("FAIL rand_valid: got %b want 1 with %0d outstanding", res_valid1, q.size()); end
      end
      if (pop) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra: popped %h with nothing outstanding", {res_op1, res_data1});
        end else begin
          e = q.pop_front();
          if ({res_op1, res_data1} !== e) begin n_fail++; $display("FAIL rand_data: got %h want %h", {res_op1, res_data1}, e); end
        end
      end
      if (acc) begin
        q.push_back({op, alu_f(op, a, b)});
        pend = 1'b0;
        sent++;
      end
      @(posedge clk); @(negedge clk);
    end
    cmd_valid1 = 1'b0; res_ready1 = 1'b0;
    n_cmp++; if (sent !== 200 || q.size() !== 0) begin n_fail++; $display("FAIL rand_complete: got sent=%0d left=%0d want 200/0", sent, q.size()); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit leak = 1'b0;
    res_ready1 = 1'b0;
    send1(3'd1, 4'd9, 4'd2, ok);
    send1(3'd2, 4'd12, 4'd10, ok);
    send1(3'd3, 4'd3, 4'd4, ok);
    n_cmp++; if ({ok, res_valid1, cmd_ready1} !== 3'b110) begin n_fail++; $display("FAIL mreset_pre: got %b want 110", {ok, res_valid1, cmd_ready1}); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if ({res_valid1, cmd_ready1} !== 2'b01) begin n_fail++; $display("FAIL mreset_flags: got %b want 01", {res_valid1, cmd_ready1}); end
    n_cmp++; if ({alu_s1, alu_a1, alu_b1} !== 11'd0) begin n_fail++; $display("FAIL mreset_alu: got %h want 0", {alu_s1, alu_a1, alu_b1}); end
    res_ready1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (res_valid1 !== 1'b0) leak = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    res_ready1 = 1'b0;
    n_cmp++; if (leak) begin n_fail++; $display("FAIL mreset_leak: got a result after reset, want none"); end
  endtask

`ifdef ALU_CMD_SEQUENCER_STATS_EN
  task automatic test_stats();
    bit ok;
    bit all_ok = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    res_ready1 = 1'b1;
    for (int k = 0; k < 17; k++) begin
      send1(3'(k), 4'(k), 4'd7, ok);
      if (!ok) all_ok = 1'b0;
    end
    n_cmp++; if (!all_ok) begin n_fail++; $display("FAIL stats_accept: a command was not accepted"); end
    n_cmp++; if (issued_cnt1 !== 4'd1) begin n_fail++; $display("FAIL stats_wrap: got %0d want 1", issued_cnt1); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (issued_cnt1 !== 4'd0) begin n_fail++; $display("FAIL stats_reset: got %0d want 0", issued_cnt1); end
    res_ready1 = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    cmd_valid1 = 1'b0; cmd_op1 = 3'd0; cmd_a1 = 4'd0; cmd_b1 = 4'd0; res_ready1 = 1'b0;
    cmd_valid3 = 1'b0; cmd_op3 = 3'd0; cmd_a3 = 4'd0; cmd_b3 = 4'd0; res_ready3 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_settle();
    test_full();
    test_random();
    test_mid_reset();
`ifdef ALU_CMD_SEQUENCER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the 4-bit ALU: accepts one {op, a, b} command per handshake and drives the ALU's select and operand inputs from registers.
- Waits a programmable settle time, then samples the ALU's 8-bit result into a small result FIFO.
- Presents results downstream with a valid/ready handshake, tagged with their opcode.
- Decouples command producers from result consumers; the combinational ALU is never driven directly by upstream logic.

Parameters:
- DEPTH, 4, result FIFO entries; power of 2, at least 2.
- SETTLE, 1, cycles the ALU inputs are held before the result is sampled; at least 1.
- CNT_W, 16, width of the issued-command counter (optional feature only).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer accepts a command this cycle.
- cmd_op  input  3  ALU select code, 0..7.
- cmd_a  input  4  operand a.
- cmd_b  input  4  operand b.
- alu_s  output  3  registered select to the ALU.
- alu_a  output  4  registered operand a to the ALU.
- alu_b  output  4  registered operand b to the ALU.
- alu_out  input  8  ALU result (combinational from alu_s, alu_a, alu_b).
- res_valid  output  1  FIFO head valid.
- res_ready  input  1  downstream consumes the head.
- res_data  output  8  FIFO head result.
- res_op  output  3  opcode that produced res_data.
- issued_cnt  output  CNT_W  commands issued (only present with the optional feature).

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; the FIFO empties (read pointer, write pointer and count all 0); the settle counter goes to 0.
  - alu_s, alu_a, alu_b are 0; res_valid is 0; res_data and res_op read 0 while the FIFO is empty.
  - Reset overrides everything. An in-flight command is dropped and its result is never written.
- FSM has two states, IDLE and DRIVE.
  - cmd_ready = (state == IDLE) && (count < DEPTH). It is purely a function of registered state.
  - IDLE: on cmd_valid && cmd_ready, load alu_s/alu_a/alu_b from cmd_op/cmd_a/cmd_b, set the settle counter to SETTLE-1 and go to DRIVE.
  - DRIVE: if the settle counter is nonzero, decrement it. If it is 0, write {alu_s, alu_out} at the FIFO write pointer, advance the pointer and return to IDLE.
- Timing:
  - A command accepted at edge t is written to the FIFO at edge t+SETTLE.
  - res_valid rises after that edge if the FIFO was empty.
  - Peak throughput is one command per SETTLE+1 cycles.
- The ALU inputs hold their last issued values in IDLE. They change only on an accept edge or on reset.
- FIFO behaviour:
  - res_valid = (count != 0).
  - res_data/res_op read combinationally from the entry at the read pointer.
  - A pop occurs on res_valid && res_ready.
  - Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - A push and a pop in the same cycle leave count unchanged, and both pointers advance.
  - A pop while empty is ignored. A push while full cannot occur, because cmd_ready is low whenever count == DEPTH.
- Command acceptance and FIFO pop are independent. A pop that frees an entry raises cmd_ready on the following cycle, not the same one.
- Results leave in command order. No result is lost or duplicated under any res_ready pattern.

Optional Feature:
- Macro: ALU_CMD_SEQUENCER_STATS_EN.
- Defined:
  - The issued_cnt port exists.
  - It increments by 1 on every accepted command, wraps modulo 2^CNT_W and resets to 0.
- Undefined:
  - No issued_cnt port and no counter logic.
  - All other behaviour is identical.

Test Plan:
- Reset, then op=0, a=5, b=3 with the real ALU attached and res_ready=1 -> alu_s/a/b = 0/5/3 after the accept edge; one cycle later res_valid=1, res_data=0x08, res_op=0; res_valid=0 after the pop.
- op=4, a=15, b=15 with SETTLE=3 -> write occurs exactly 3 cycles after acceptance; res_data=0xE1, res_op=4; cmd_ready stays low throughout DRIVE.
- res_ready=0 with DEPTH=4 and back-to-back commands a=1..5, b=1, op=0 -> exactly 4 accepted; cmd_ready stays 0 with command 5 pending; after one pop, command 5 is accepted on a later cycle; results 2,3,4,5,6 emerge in order.
- Random res_ready toggling over 200 random commands with simultaneous push/pop -> output stream matches the ALU model in order; count never exceeds DEPTH; pointers wrap correctly.
- rst_n low during DRIVE with 2 results queued -> next cycle res_valid=0, cmd_ready=1, alu_s/a/b=0; the aborted result never appears.
- With ALU_CMD_SEQUENCER_STATS_EN defined and CNT_W=4, issue 17 commands -> issued_cnt=1 (wrapped); reset returns it to 0.
